// File: rtl/gtfmac_hwchk_bitslip_pkg.sv
// gtfmac_hwchk_bitslip_pkg
//   Shared definitions for the multi-channel bitslip correction engine:
//   the per-channel FSM state encoding, the synchroniser depth and the
//   parameter-legality helper used at elaboration.
package gtfmac_hwchk_bitslip_pkg;

  typedef enum logic [2:0] {
    ST_SYNC    = 3'd0,
    ST_LOCKED  = 3'd1,
    ST_CORRECT = 3'd2,
    ST_ACK     = 3'd3,
    ST_RESYNC  = 3'd4,
    ST_DONE    = 3'd5
  } bs_state_e;

  localparam int unsigned SYNC_DEPTH = 3;

  // rxslippma can only remove 1 or 2 UI per handshake
  function automatic bit pma_slip_ui_legal(input int unsigned ui);
    return (ui == 1) || (ui == 2);
  endfunction

endpackage

// File: rtl/gtfmac_hwchk_bitslip_ch.sv
// gtfmac_hwchk_bitslip_ch
//   One channel of the bitslip correction engine: input synchronisers,
//   rx_bitslip edge counter, lock qualification and the correction FSM.
//   Optional ACK timeout is built only with GTFMAC_BITSLIP_RDY_TIMEOUT_EN.
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   i_gb_seq_sync                user seq-sync, ORed into o_gb_seq_sync
//   i_disable_bitslip            async, synchronised, ORed into o_disable_bitslip
//   i_correct_bitslip            async level, synchronised, starts correction
//   i_auto_correct               start correction without i_correct_bitslip
//   i_rearm                      async, synchronised, rising edge leaves DONE
//   i_rx_data_rate               1 = 25G (no correction), 0 = 10G
//   i_block_lock, i_bitslip, i_slip_pma_rdy   GTF status
//   o_gb_seq_sync, o_disable_bitslip, o_slip_pma, o_slip_one_ui  GTF controls
//   o_bitslip_cnt, o_bitslip_issued          counters
//   o_locked, o_busy, o_done, o_excessive, o_timeout, o_lock_lost  status
module gtfmac_hwchk_bitslip_ch
  import gtfmac_hwchk_bitslip_pkg::*;
#(
  parameter int unsigned CNT_W        = 7,
  parameter int unsigned PMA_SLIP_UI  = 2,
  parameter int unsigned LOCK_QUAL    = 8,
  parameter int unsigned SEQ_SYNC_LEN = 8,
  parameter int unsigned RDY_TIMEOUT  = 1023
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_gb_seq_sync,
  input  logic             i_disable_bitslip,
  input  logic             i_correct_bitslip,
  input  logic             i_auto_correct,
  input  logic             i_rearm,
  input  logic             i_rx_data_rate,
  input  logic             i_block_lock,
  input  logic             i_bitslip,
  input  logic             i_slip_pma_rdy,
  output logic             o_gb_seq_sync,
  output logic             o_disable_bitslip,
  output logic             o_slip_pma,
  output logic             o_slip_one_ui,
  output logic [CNT_W-1:0] o_bitslip_cnt,
  output logic [CNT_W-1:0] o_bitslip_issued,
  output logic             o_locked,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_excessive,
  output logic             o_timeout,
  output logic             o_lock_lost
);

  localparam int unsigned RUN_W = (LOCK_QUAL < 1) ? 1 : $clog2(LOCK_QUAL + 1);
  localparam int unsigned SEQ_W = (SEQ_SYNC_LEN < 2) ? 1 : $clog2(SEQ_SYNC_LEN + 1);

  if (RDY_TIMEOUT == 0) begin : g_bad_timeout
    $error("RDY_TIMEOUT must be at least 1");
  end

  logic [SYNC_DEPTH-1:0] r_dis_sync, r_cor_sync, r_rearm_sync;
  logic                  r_rearm_d;
  logic [1:0]            r_bs_d;
  logic                  r_bs_edge;
  logic [RUN_W-1:0]      r_run;
  logic                  r_locked, r_locked_d;

  bs_state_e             r_state;
  logic [CNT_W-1:0]      r_cnt, r_issued, r_delta;
  logic [SEQ_W-1:0]      r_seq_cnt;
  logic                  r_seq_sync, r_sm_disable, r_slip_pma, r_one_ui;
  logic                  r_done, r_excessive, r_lock_lost;

  logic w_rearm_rise, w_start, w_hs_clear, w_hs_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dis_sync   <= '0;
      r_cor_sync   <= '0;
      r_rearm_sync <= '0;
      r_rearm_d    <= 1'b0;
      r_bs_d       <= '0;
      r_bs_edge    <= 1'b0;
    end else begin
      r_dis_sync   <= {r_dis_sync[SYNC_DEPTH-2:0], i_disable_bitslip};
      r_cor_sync   <= {r_cor_sync[SYNC_DEPTH-2:0], i_correct_bitslip};
      r_rearm_sync <= {r_rearm_sync[SYNC_DEPTH-2:0], i_rearm};
      r_rearm_d    <= r_rearm_sync[SYNC_DEPTH-1];
      r_bs_d       <= {r_bs_d[0], i_bitslip};
      r_bs_edge    <= r_bs_d[0] & ~r_bs_d[1];
    end
  end

  // Run counter saturates at LOCK_QUAL; only the threshold matters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_run      <= '0;
      r_locked   <= 1'b0;
      r_locked_d <= 1'b0;
    end else begin
      if (!i_block_lock)
        r_run <= '0;
      else if (r_run < RUN_W'(LOCK_QUAL))
        r_run <= r_run + RUN_W'(1);
      r_locked   <= (r_run >= RUN_W'(LOCK_QUAL));
      r_locked_d <= r_locked;
    end
  end

  assign w_rearm_rise = r_rearm_sync[SYNC_DEPTH-1] & ~r_rearm_d;
  assign w_start      = r_cor_sync[SYNC_DEPTH-1] | i_auto_correct;
  assign w_hs_clear   = r_slip_pma & ~i_slip_pma_rdy;
  assign w_hs_done    = ~r_slip_pma & i_slip_pma_rdy;

`ifdef GTFMAC_BITSLIP_RDY_TIMEOUT_EN
  localparam int unsigned TO_W = (RDY_TIMEOUT < 2) ? 1 : $clog2(RDY_TIMEOUT + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;
  logic            w_to_hit;
  assign w_to_hit  = (r_to_cnt == TO_W'(RDY_TIMEOUT - 1));
  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_SYNC;
      r_cnt        <= '0;
      r_issued     <= '0;
      r_delta      <= '0;
      r_seq_cnt    <= '0;
      r_seq_sync   <= 1'b0;
      r_sm_disable <= 1'b0;
      r_slip_pma   <= 1'b0;
      r_one_ui     <= 1'b0;
      r_done       <= 1'b0;
      r_excessive  <= 1'b0;
      r_lock_lost  <= 1'b0;
`ifdef GTFMAC_BITSLIP_RDY_TIMEOUT_EN
      r_to_cnt     <= '0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_SYNC: begin
          r_sm_disable <= 1'b0;
          if (r_bs_edge && (r_cnt == '1)) begin
            r_excessive <= 1'b1;
            r_done      <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            // an edge coinciding with lock qualification is still counted
            if (r_bs_edge)
              r_cnt <= r_cnt + CNT_W'(1);
            if (r_locked) begin
              if (i_rx_data_rate) begin
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_sm_disable <= 1'b1;
                r_state      <= ST_LOCKED;
              end
            end
          end
        end
        ST_LOCKED: begin
          if (w_start) begin
            r_delta <= r_cnt - r_issued;
            r_state <= ST_CORRECT;
          end
        end
        ST_CORRECT: begin
          if (r_delta >= CNT_W'(PMA_SLIP_UI)) begin
            r_slip_pma <= 1'b1;
            r_issued   <= r_issued + CNT_W'(PMA_SLIP_UI);
`ifdef GTFMAC_BITSLIP_RDY_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
            r_state    <= ST_ACK;
          end else if (r_delta != '0) begin
            r_one_ui <= 1'b1;
            r_issued <= r_issued + CNT_W'(1);
            r_delta  <= '0;
          end else begin
            r_seq_sync <= 1'b1;
            r_seq_cnt  <= SEQ_W'(SEQ_SYNC_LEN - 1);
            r_state    <= ST_RESYNC;
          end
        end
        ST_ACK: begin
`ifdef GTFMAC_BITSLIP_RDY_TIMEOUT_EN
          if (w_to_hit) begin
            r_slip_pma <= 1'b0;
            r_timeout  <= 1'b1;
            r_done     <= 1'b1;
            r_state    <= ST_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
            if (w_hs_clear)
              r_slip_pma <= 1'b0;
            else if (w_hs_done) begin
              r_delta <= r_cnt - r_issued;
              r_state <= ST_CORRECT;
            end
          end
`else
          if (w_hs_clear)
            r_slip_pma <= 1'b0;
          else if (w_hs_done) begin
            r_delta <= r_cnt - r_issued;
            r_state <= ST_CORRECT;
          end
`endif
        end
        ST_RESYNC: begin
          // seq_sync high for SEQ_SYNC_LEN cycles, then one idle cycle
          if (r_seq_cnt != '0)
            r_seq_cnt <= r_seq_cnt - SEQ_W'(1);
          else if (r_seq_sync)
            r_seq_sync <= 1'b0;
          else begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (r_locked_d && !r_locked && !i_rx_data_rate)
            r_lock_lost <= 1'b1;
          if (w_rearm_rise) begin
            r_cnt       <= '0;
            r_issued    <= '0;
            r_done      <= 1'b0;
            r_lock_lost <= 1'b0;
            r_excessive <= 1'b0;
            r_one_ui    <= 1'b0;
`ifdef GTFMAC_BITSLIP_RDY_TIMEOUT_EN
            r_timeout   <= 1'b0;
`endif
            r_state     <= ST_SYNC;
          end
        end
        default: r_state <= ST_SYNC;
      endcase
    end
  end

  assign o_gb_seq_sync     = r_seq_sync | i_gb_seq_sync;
  assign o_disable_bitslip = r_sm_disable | r_dis_sync[SYNC_DEPTH-1];
  assign o_slip_pma        = r_slip_pma;
  assign o_slip_one_ui     = r_one_ui;
  assign o_bitslip_cnt     = r_cnt;
  assign o_bitslip_issued  = r_issued;
  assign o_locked          = r_locked;
  assign o_busy            = (r_state == ST_CORRECT) || (r_state == ST_ACK) ||
                             (r_state == ST_RESYNC);
  assign o_done            = r_done;
  assign o_excessive       = r_excessive;
  assign o_lock_lost       = r_lock_lost;

endmodule

// File: rtl/gtfmac_hwchk_bitslip_mc.sv
// gtfmac_hwchk_bitslip_mc
//   Multi-channel bitslip correction engine: NUM_CH independent channels
//   plus aggregate done/error status. Macro GTFMAC_BITSLIP_RDY_TIMEOUT_EN
//   enables the rxslippma handshake timeout (stat_timeout otherwise 0).
// Ports (per-channel vectors are NUM_CH wide, counters NUM_CH*CNT_W packed,
// channel 0 in the LSBs):
//   rx_clk, rx_rst          shared clock, async active-high reset
//   ctl_*                   user controls (ctl_auto_correct is shared)
//   rx_block_lock, rx_bitslip, rx_slip_pma_rdy   GTF status
//   bs_*                    GTF controls
//   stat_*                  per-channel status
//   stat_all_done           AND of stat_done
//   stat_any_error          OR of excessive/timeout/lock_lost over channels
module gtfmac_hwchk_bitslip_mc
  import gtfmac_hwchk_bitslip_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 7,
  parameter int unsigned PMA_SLIP_UI  = 2,
  parameter int unsigned LOCK_QUAL    = 8,
  parameter int unsigned SEQ_SYNC_LEN = 8,
  parameter int unsigned RDY_TIMEOUT  = 1023
) (
  input  logic                    rx_clk,
  input  logic                    rx_rst,
  input  logic [NUM_CH-1:0]       ctl_gb_seq_sync,
  input  logic [NUM_CH-1:0]       ctl_disable_bitslip,
  input  logic [NUM_CH-1:0]       ctl_correct_bitslip,
  input  logic                    ctl_auto_correct,
  input  logic [NUM_CH-1:0]       ctl_rearm,
  input  logic [NUM_CH-1:0]       ctl_rx_data_rate,
  input  logic [NUM_CH-1:0]       rx_block_lock,
  input  logic [NUM_CH-1:0]       rx_bitslip,
  input  logic [NUM_CH-1:0]       rx_slip_pma_rdy,
  output logic [NUM_CH-1:0]       bs_gb_seq_sync,
  output logic [NUM_CH-1:0]       bs_disable_bitslip,
  output logic [NUM_CH-1:0]       bs_slip_pma,
  output logic [NUM_CH-1:0]       bs_slip_one_ui,
  output logic [NUM_CH*CNT_W-1:0] stat_bitslip_cnt,
  output logic [NUM_CH*CNT_W-1:0] stat_bitslip_issued,
  output logic [NUM_CH-1:0]       stat_locked,
  output logic [NUM_CH-1:0]       stat_busy,
  output logic [NUM_CH-1:0]       stat_done,
  output logic [NUM_CH-1:0]       stat_excessive_bitslip,
  output logic [NUM_CH-1:0]       stat_timeout,
  output logic [NUM_CH-1:0]       stat_lock_lost,
  output logic                    stat_all_done,
  output logic                    stat_any_error
);

  if (!pma_slip_ui_legal(PMA_SLIP_UI)) begin : g_bad_pma_slip_ui
    $error("PMA_SLIP_UI must be 1 or 2");
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    gtfmac_hwchk_bitslip_ch #(
      .CNT_W        (CNT_W),
      .PMA_SLIP_UI  (PMA_SLIP_UI),
      .LOCK_QUAL    (LOCK_QUAL),
      .SEQ_SYNC_LEN (SEQ_SYNC_LEN),
      .RDY_TIMEOUT  (RDY_TIMEOUT)
    ) u_ch (
      .i_clk             (rx_clk),
      .i_rst             (rx_rst),
      .i_gb_seq_sync     (ctl_gb_seq_sync[g]),
      .i_disable_bitslip (ctl_disable_bitslip[g]),
      .i_correct_bitslip (ctl_correct_bitslip[g]),
      .i_auto_correct    (ctl_auto_correct),
      .i_rearm           (ctl_rearm[g]),
      .i_rx_data_rate    (ctl_rx_data_rate[g]),
      .i_block_lock      (rx_block_lock[g]),
      .i_bitslip         (rx_bitslip[g]),
      .i_slip_pma_rdy    (rx_slip_pma_rdy[g]),
      .o_gb_seq_sync     (bs_gb_seq_sync[g]),
      .o_disable_bitslip (bs_disable_bitslip[g]),
      .o_slip_pma        (bs_slip_pma[g]),
      .o_slip_one_ui     (bs_slip_one_ui[g]),
      .o_bitslip_cnt     (stat_bitslip_cnt[g*CNT_W +: CNT_W]),
      .o_bitslip_issued  (stat_bitslip_issued[g*CNT_W +: CNT_W]),
      .o_locked          (stat_locked[g]),
      .o_busy            (stat_busy[g]),
      .o_done            (stat_done[g]),
      .o_excessive       (stat_excessive_bitslip[g]),
      .o_timeout         (stat_timeout[g]),
      .o_lock_lost       (stat_lock_lost[g])
    );
  end

  assign stat_all_done  = &stat_done;
  assign stat_any_error = |{stat_excessive_bitslip, stat_timeout, stat_lock_lost};

endmodule

// File: tb/tb_gtfmac_hwchk_bitslip_mc.sv
module tb_gtfmac_hwchk_bitslip_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut0: default parameters, 4 channels
  logic [3:0]  gbs0 = '0, dis0 = '0, cor0 = '0, rearm0 = '0, rate0 = '0;
  logic [3:0]  lock0 = '0, bslip0 = '0, resp_en0 = '1;
  logic        auto0 = 1'b0;
  logic [3:0]  rdy0;
  logic [3:0]  seq0, bdis0, pma0, oneui0, locked0, busy0, done0, exc0, to0, ll0;
  logic [27:0] cnt0, iss0;
  logic        alld0, anyerr0;

  // dut1: single channel, 1 UI per handshake, short timeout
  logic [0:0]  gbs1 = '0, dis1 = '0, cor1 = '0, rearm1 = '0, rate1 = '0;
  logic [0:0]  lock1 = '0, bslip1 = '0;
  logic        auto1 = 1'b0, resp_en1 = 1'b1;
  logic [0:0]  rdy1;
  logic [0:0]  seq1, bdis1, pma1, oneui1, locked1, busy1, done1, exc1, to1, ll1;
  logic [6:0]  cnt1, iss1;
  logic        alld1, anyerr1;

  gtfmac_hwchk_bitslip_mc u_dut0 (
    .rx_clk(clk), .rx_rst(rst),
    .ctl_gb_seq_sync(gbs0), .ctl_disable_bitslip(dis0), .ctl_correct_bitslip(cor0),
    .ctl_auto_correct(auto0), .ctl_rearm(rearm0), .ctl_rx_data_rate(rate0),
    .rx_block_lock(lock0), .rx_bitslip(bslip0), .rx_slip_pma_rdy(rdy0),
    .bs_gb_seq_sync(seq0), .bs_disable_bitslip(bdis0), .bs_slip_pma(pma0),
    .bs_slip_one_ui(oneui0), .stat_bitslip_cnt(cnt0), .stat_bitslip_issued(iss0),
    .stat_locked(locked0), .stat_busy(busy0), .stat_done(done0),
    .stat_excessive_bitslip(exc0), .stat_timeout(to0), .stat_lock_lost(ll0),
    .stat_all_done(alld0), .stat_any_error(anyerr0)
  );

  gtfmac_hwchk_bitslip_mc #(
    .NUM_CH(1), .CNT_W(7), .PMA_SLIP_UI(1), .LOCK_QUAL(8),
    .SEQ_SYNC_LEN(8), .RDY_TIMEOUT(15)
  ) u_dut1 (
    .rx_clk(clk), .rx_rst(rst),
    .ctl_gb_seq_sync(gbs1), .ctl_disable_bitslip(dis1), .ctl_correct_bitslip(cor1),
    .ctl_auto_correct(auto1), .ctl_rearm(rearm1), .ctl_rx_data_rate(rate1),
    .rx_block_lock(lock1), .rx_bitslip(bslip1), .rx_slip_pma_rdy(rdy1),
    .bs_gb_seq_sync(seq1), .bs_disable_bitslip(bdis1), .bs_slip_pma(pma1),
    .bs_slip_one_ui(oneui1), .stat_bitslip_cnt(cnt1), .stat_bitslip_issued(iss1),
    .stat_locked(locked1), .stat_busy(busy1), .stat_done(done1),
    .stat_excessive_bitslip(exc1), .stat_timeout(to1), .stat_lock_lost(ll1),
    .stat_all_done(alld1), .stat_any_error(anyerr1)
  );

  // rxslippma responders: rdy idles high, dips low for 3 cycles per request
  for (genvar g = 0; g < 4; g++) begin : g_resp0
    logic rdy_l = 1'b1;
    int   hs  = 0;
    int   seq = 0;
    assign rdy0[g] = rdy_l;
    always begin
      @(posedge pma0[g]);
      hs++;
      if (resp_en0[g]) begin
        repeat (2) @(negedge clk);
        rdy_l = 1'b0;
        repeat (3) @(negedge clk);
        rdy_l = 1'b1;
      end
    end
    always @(negedge clk) if (seq0[g]) seq++;
  end

  logic rdy1_l = 1'b1;
  int   hs1 = 0;
  int   seqc1 = 0;
  assign rdy1[0] = rdy1_l;
  always begin
    @(posedge pma1[0]);
    hs1++;
    if (resp_en1) begin
      repeat (2) @(negedge clk);
      rdy1_l = 1'b0;
      repeat (3) @(negedge clk);
      rdy1_l = 1'b1;
    end
  end
  always @(negedge clk) if (seq1[0]) seqc1++;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulses0(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      bslip0[ch] = 1'b1; tick(1);
      bslip0[ch] = 1'b0; tick(1);
    end
  endtask

  task automatic pulses1(input int n);
    for (int i = 0; i < n; i++) begin
      bslip1[0] = 1'b1; tick(1);
      bslip1[0] = 1'b0; tick(1);
    end
  endtask

  task automatic wait_done0(input int ch, input int budget);
    for (int i = 0; i < budget && !done0[ch]; i++) tick(1);
  endtask

  task automatic wait_pma0(input int ch, input int budget);
    for (int i = 0; i < budget && !pma0[ch]; i++) tick(1);
  endtask

  int hs_b, seq_b;

  initial begin
    // ---- reset state ----
    tick(3);
    chk("rst_pma",    64'(pma0), 64'h0);
    chk("rst_cnt",    64'(cnt0), 64'h0);
    chk("rst_done",   64'(done0), 64'h0);
    rst = 1'b0;
    tick(2);
    chk("idle_locked", 64'(locked0), 64'h0);
    chk("idle_busy",   64'(busy0), 64'h0);
    chk("idle_err",    64'(anyerr0), 64'h0);

    // ---- 1: ch0, 5 slips, 2 UI per handshake ----
    pulses0(0, 5);
    tick(4);
    chk("t1_cnt", 64'(cnt0[6:0]), 64'd5);
    hs_b  = g_resp0[0].hs;
    seq_b = g_resp0[0].seq;
    cor0[0]  = 1'b1;
    lock0[0] = 1'b1;
    wait_done0(0, 400);
    chk("t1_done",    64'(done0[0]), 64'h1);
    chk("t1_busy",    64'(busy0[0]), 64'h0);
    chk("t1_issued",  64'(iss0[6:0]), 64'd5);
    chk("t1_hs",      64'(g_resp0[0].hs - hs_b), 64'd2);
    chk("t1_one_ui",  64'(oneui0[0]), 64'h1);
    chk("t1_seq_len", 64'(g_resp0[0].seq - seq_b), 64'd8);
    chk("t1_disable", 64'(bdis0[0]), 64'h1);
    chk("t1_alldone", 64'(alld0), 64'h0);

    // ---- 2: dut1, 1 UI per handshake, auto-correct ----
    auto1 = 1'b1;
    pulses1(3);
    tick(4);
    hs_b = hs1;
    lock1[0] = 1'b1;
    for (int i = 0; i < 400 && !done1[0]; i++) tick(1);
    chk("t2_done",   64'(done1[0]), 64'h1);
    chk("t2_hs",     64'(hs1 - hs_b), 64'd3);
    chk("t2_one_ui", 64'(oneui1[0]), 64'h0);
    chk("t2_issued", 64'(iss1), 64'd3);

    // ---- 3: ch3, counter overflow ----
    hs_b = g_resp0[3].hs;
    pulses0(3, 128);
    tick(4);
    chk("t3_cnt",    64'(cnt0[27:21]), 64'd127);
    chk("t3_exc",    64'(exc0[3]), 64'h1);
    chk("t3_done",   64'(done0[3]), 64'h1);
    chk("t3_issued", 64'(iss0[27:21]), 64'd0);
    chk("t3_hs",     64'(g_resp0[3].hs - hs_b), 64'd0);
    chk("t3_anyerr", 64'(anyerr0), 64'h1);

    // ---- 4: dut1, rdy held high in ACK ----
    lock1[0] = 1'b0;
    tick(20);
    rearm1[0] = 1'b1; tick(5);
    rearm1[0] = 1'b0; tick(5);
    chk("t4_rearm_ll",  64'(ll1[0]), 64'h0);
    chk("t4_rearm_cnt", 64'(cnt1), 64'd0);
    resp_en1 = 1'b0;
    pulses1(2);
    tick(4);
    seq_b = seqc1;
    lock1[0] = 1'b1;
    for (int i = 0; i < 100 && !pma1[0]; i++) tick(1);
    chk("t4_ack_enter", 64'(pma1[0]), 64'h1);
    tick(12);
    chk("t4_ack_hold",  64'(pma1[0]), 64'h1);
    chk("t4_not_done",  64'(done1[0]), 64'h0);
`ifdef GTFMAC_BITSLIP_RDY_TIMEOUT_EN
    tick(6);
    chk("t4_to_done",  64'(done1[0]), 64'h1);
    chk("t4_to_flag",  64'(to1[0]), 64'h1);
    chk("t4_to_pma",   64'(pma1[0]), 64'h0);
    chk("t4_to_noseq", 64'(seqc1 - seq_b), 64'd0);
    chk("t4_to_err",   64'(anyerr1), 64'h1);
`else
    tick(30);
    chk("t4_wait_pma",  64'(pma1[0]), 64'h1);
    chk("t4_wait_to",   64'(to1[0]), 64'h0);
    chk("t4_wait_busy", 64'(busy1[0]), 64'h1);
`endif

    // ---- 5: ch0, lock lost in DONE then re-arm ----
    lock0[0] = 1'b0;
    tick(20);
    chk("t5_ll",      64'(ll0[0]), 64'h1);
    chk("t5_ll_done", 64'(done0[0]), 64'h1);
    rearm0[0] = 1'b1; tick(5);
    rearm0[0] = 1'b0; tick(5);
    chk("t5_clr_cnt",  64'(cnt0[6:0]), 64'd0);
    chk("t5_clr_iss",  64'(iss0[6:0]), 64'd0);
    chk("t5_clr_done", 64'(done0[0]), 64'h0);
    chk("t5_clr_ll",   64'(ll0[0]), 64'h0);
    chk("t5_clr_ui",   64'(oneui0[0]), 64'h0);
    chk("t5_clr_dis",  64'(bdis0[0]), 64'h0);
    hs_b = g_resp0[0].hs;
    pulses0(0, 3);
    tick(4);
    chk("t5_cnt", 64'(cnt0[6:0]), 64'd3);
    lock0[0] = 1'b1;
    wait_done0(0, 400);
    chk("t5_done",   64'(done0[0]), 64'h1);
    chk("t5_issued", 64'(iss0[6:0]), 64'd3);
    chk("t5_hs",     64'(g_resp0[0].hs - hs_b), 64'd1);
    chk("t5_one_ui", 64'(oneui0[0]), 64'h1);

    // ---- 6: async reset with ch1 stuck in ACK, ch2 at 25G ----
    resp_en0[1] = 1'b0;
    cor0[1]  = 1'b1;
    rate0[2] = 1'b1;
    pulses0(1, 4);
    pulses0(2, 2);
    tick(4);
    lock0[1] = 1'b1;
    lock0[2] = 1'b1;
    wait_pma0(1, 100);
    chk("t6_ack", 64'(pma0[1]), 64'h1);
    wait_done0(2, 100);
    chk("t6_ch2_done", 64'(done0[2]), 64'h1);
    chk("t6_ch2_dis",  64'(bdis0[2]), 64'h0);
    chk("t6_ch2_cnt",  64'(cnt0[20:14]), 64'd2);
    tick(3);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_pma",  64'(pma0), 64'h0);
    chk("t6_rst_ui",   64'(oneui0), 64'h0);
    chk("t6_rst_dis",  64'(bdis0), 64'h0);
    chk("t6_rst_done", 64'(done0), 64'h0);
    chk("t6_rst_cnt",  64'(cnt0), 64'h0);
    chk("t6_rst_iss",  64'(iss0), 64'h0);
    chk("t6_rst_err",  64'(anyerr0), 64'h0);
    tick(2);
    rst = 1'b0;
    wait_done0(2, 100);
    chk("t6_relock_done", 64'(done0[2]), 64'h1);
    chk("t6_relock_dis",  64'(bdis0[2]), 64'h0);
    chk("t6_relock_cnt",  64'(cnt0[20:14]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
